cdb_broadcast_scheduler: RTL and testbench
==========================================

Name: cdb_broadcast_scheduler

Overview:
- Registered, buffered replacement for the combinational CDB mux.
- Each functional unit (multiplier, adder, memory) pushes completed results {tag, data} into a small per-unit result queue.
- Each cycle the scheduler grants one queue head onto the Common Data Bus. It uses fixed priority mul > add > mem, plus an anti-starvation override.
- It raises dispatch_stall to the dispatch/decode unit when buffered results back up. Stalls are then only needed under real congestion, not on every multi-unit completion.

Parameters:
- DEPTH, 2, entries per result queue (≥2).
- STARVE_LIMIT, 4, cycles a non-empty head may wait ungranted before it gets override priority (≥1).
- STALL_THRESH, 3, total buffered entries across all queues at or above which dispatch_stall asserts.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  broadcast enable; 0 freezes grants and wait counters.
- mul_tag  in  8  multiplier result tag; bit7 = valid.
- mul_data  in  32  multiplier result data.
- mul_ready  out  1  multiplier queue can accept a push.
- add_tag  in  8  adder result tag; bit7 = valid.
- add_data  in  32  adder result data.
- add_ready  out  1  adder queue can accept a push.
- mem_tag  in  8  memory unit result tag; bit7 = valid.
- mem_data  in  32  memory unit result data.
- mem_ready  out  1  memory queue can accept a push.
- cdb_tag  out  8  broadcast tag, registered; bit7 = 1 when broadcasting, else 8'd0.
- cdb_data  out  32  broadcast data, registered; 32'd0 when idle.
- cdb_src  out  2  source of current broadcast: 0 none, 1 mul, 2 add, 3 mem.
- dispatch_stall  out  1  stall new dispatches.

Behaviour:
- Reset (reset=0, async): all queues empty, all wait counters 0, cdb_tag=0, cdb_data=0, cdb_src=0. Therefore *_ready=1 and dispatch_stall=0.
- Push:
  - Occurs at the rising edge when X_tag[7]=1 and X_ready=1; {tag, data} is appended to queue X.
  - X_ready = (count_X < DEPTH), combinational from count only. There is no pop-through: a full queue is not ready even if it pops this cycle.
  - If tag[7]=1 and ready=0, nothing is stored. The unit must hold its result until ready.
  - Pushes are accepted regardless of en.
- Arbitration (combinational, from registered state):
  - eligible_X = queue X non-empty and en=1.
  - If any eligible queue has wait_X ≥ STARVE_LIMIT, grant the first starved queue in order mul, add, mem.
  - Otherwise grant the first eligible queue in order mul, add, mem.
  - At most one grant per cycle.
- Broadcast:
  - On the edge, the granted head is popped and registered into cdb_tag/cdb_data/cdb_src.
  - If there is no grant, outputs go to 0 at that edge.
  - Latency: a result pushed at edge N into an empty queue with no competition appears on cdb_* after edge N+1 and is held for exactly one cycle.
  - Push and pop on the same queue in the same edge are both legal; count is unchanged.
- Wait counters:
  - wait_X increments (saturating at STARVE_LIMIT) when eligible_X and not granted.
  - wait_X clears when X is granted or X is empty.
  - wait_X holds when en=0.
- dispatch_stall = (count_mul + count_add + count_mem ≥ STALL_THRESH) OR any count_X == DEPTH. Combinational from registered counts.
- FIFO pointers wrap modulo DEPTH; count width is clog2(DEPTH+1).
- en=0: no pops; cdb_tag/cdb_data/cdb_src go to 0 at the next edge; queue contents are retained.
- Reset mid-operation: queued results are discarded immediately. Outputs take reset values asynchronously.

Test Plan:
- Single result: mul_tag=8'h85, mul_data=32'd42 for one cycle → cdb_tag=8'h85, cdb_data=42, cdb_src=1 exactly one cycle later, then cdb_tag=0.
- Simultaneous completion: mul 8'h81, add 8'h82, mem 8'h83 pushed at the same edge → broadcasts 81, 82, 83 on three consecutive cycles. dispatch_stall=1 the cycle after the push (total 3), 0 once total ≤ 2.
- Backpressure: hold en=0, push two add results (8'h90, 8'h91) → add_ready=0 and dispatch_stall=1. A third push of 8'h92 is dropped. Then set en=1 → 90, 91 broadcast in order; 92 never appears.
- Starvation: keep the mul queue continuously non-empty while one mem result (8'hA0) waits → A0 is broadcast on the cycle its wait reaches 4, preempting mul. Its wait counter then clears.
- Reset mid-operation: queues hold 3 entries; assert reset low asynchronously mid-cycle → cdb_tag=0, all ready=1, dispatch_stall=0 immediately. No stale broadcast after release.

Source files
------------

// File: rtl/cdb_broadcast_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cdb_broadcast_scheduler                                                  |
// | Buffers FU results per unit and grants one head per cycle onto the CDB.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cdb_broadcast_scheduler #(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4,
   parameter int STALL_THRESH = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [7:0]  mul_tag,
   input  logic [31:0] mul_data,
   output logic        mul_ready,
   input  logic [7:0]  add_tag,
   input  logic [31:0] add_data,
   output logic        add_ready,
   input  logic [7:0]  mem_tag,
   input  logic [31:0] mem_data,
   output logic        mem_ready,
   output logic [7:0]  cdb_tag,
   output logic [31:0] cdb_data,
   output logic [1:0]  cdb_src,
   output logic        dispatch_stall
);

   localparam int c_cw = $clog2(DEPTH + 1);
   localparam int c_pw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_ww = $clog2(STARVE_LIMIT + 1);
   localparam int c_sw = c_cw + 2;
   localparam logic [c_cw-1:0] c_depth = c_cw'(DEPTH);
   localparam logic [c_pw-1:0] c_last  = c_pw'(DEPTH - 1);
   localparam logic [c_ww-1:0] c_limit = c_ww'(STARVE_LIMIT);
   localparam logic [c_sw-1:0] c_thresh = c_sw'(STALL_THRESH);

   // Unit index 0 = mul, 1 = add, 2 = mem; this order is also the priority order.
   logic [2:0][7:0]       in_tag;
   logic [2:0][31:0]      in_data;
   logic [2:0][7:0]       head_tag;
   logic [2:0][31:0]      head_data;
   logic [2:0][c_cw-1:0]  cnt;
   logic [2:0]            ready, push, elig, starved, grant;
   logic [c_sw-1:0]       total;

   logic [7:0]  cdb_tag_q;
   logic [31:0] cdb_data_q;
   logic [1:0]  cdb_src_q;

   assign in_tag  = {mem_tag, add_tag, mul_tag};
   assign in_data = {mem_data, add_data, mul_data};

   for (genvar u = 0; u < 3; u++) begin : g_unit
      logic [7:0]      tag_mem  [DEPTH];
      logic [31:0]     data_mem [DEPTH];
      logic [c_pw-1:0] wr_q, wr_d, rd_q, rd_d;
      logic [c_cw-1:0] cnt_q, cnt_d;
      logic [c_ww-1:0] wait_q, wait_d;

      assign cnt[u]       = cnt_q;
      assign ready[u]     = (cnt_q < c_depth);
      assign push[u]      = in_tag[u][7] & ready[u];
      assign elig[u]      = (cnt_q != '0) & en;
      assign starved[u]   = elig[u] & (wait_q >= c_limit);
      assign head_tag[u]  = tag_mem[rd_q];
      assign head_data[u] = data_mem[rd_q];

      always_comb begin
         wr_d   = wr_q;
         rd_d   = rd_q;
         cnt_d  = cnt_q;
         wait_d = wait_q;
         if (push[u]) wr_d = (wr_q == c_last) ? '0 : wr_q + 1'b1;
         if (grant[u]) rd_d = (rd_q == c_last) ? '0 : rd_q + 1'b1;
         unique case ({push[u], grant[u]})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
         // Wait age is frozen while broadcasting is disabled.
         if (en) begin
            if (grant[u] || cnt_q == '0) wait_d = '0;
            else if (wait_q < c_limit)   wait_d = wait_q + 1'b1;
         end
      end

      always_ff @(posedge clk) begin
         if (push[u]) begin
            tag_mem[wr_q]  <= in_tag[u];
            data_mem[wr_q] <= in_data[u];
         end
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            wait_q <= '0;
         end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            wait_q <= wait_d;
         end
      end
   end

   always_comb begin
      grant = '0;
      if (|starved) begin
         if (starved[0])      grant = 3'b001;
         else if (starved[1]) grant = 3'b010;
         else                 grant = 3'b100;
      end else begin
         if (elig[0])         grant = 3'b001;
         else if (elig[1])    grant = 3'b010;
         else if (elig[2])    grant = 3'b100;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cdb_tag_q  <= '0;
         cdb_data_q <= '0;
         cdb_src_q  <= '0;
      end else if (grant[0]) begin
         cdb_tag_q  <= head_tag[0];
         cdb_data_q <= head_data[0];
         cdb_src_q  <= 2'd1;
      end else if (grant[1]) begin
         cdb_tag_q  <= head_tag[1];
         cdb_data_q <= head_data[1];
         cdb_src_q  <= 2'd2;
      end else if (grant[2]) begin
         cdb_tag_q  <= head_tag[2];
         cdb_data_q <= head_data[2];
         cdb_src_q  <= 2'd3;
      end else begin
         cdb_tag_q  <= '0;
         cdb_data_q <= '0;
         cdb_src_q  <= '0;
      end
   end

   assign total          = c_sw'(cnt[0]) + c_sw'(cnt[1]) + c_sw'(cnt[2]);
   assign dispatch_stall = (total >= c_thresh) | (cnt[0] == c_depth) |
                           (cnt[1] == c_depth) | (cnt[2] == c_depth);

   assign mul_ready = ready[0];
   assign add_ready = ready[1];
   assign mem_ready = ready[2];
   assign cdb_tag   = cdb_tag_q;
   assign cdb_data  = cdb_data_q;
   assign cdb_src   = cdb_src_q;

endmodule
`default_nettype wire

// File: tb/tb_cdb_broadcast_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cdb_broadcast_scheduler                                               |
// | Directed and random stimulus against a queue-based reference model.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_cdb_broadcast_scheduler;

   localparam int DEPTH  = 2;
   localparam int LIMIT  = 4;
   localparam int THRESH = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic [7:0]  utag  [3];
   logic [31:0] udata [3];
   logic        mul_ready, add_ready, mem_ready;
   logic [7:0]  cdb_tag;
   logic [31:0] cdb_data;
   logic [1:0]  cdb_src;
   logic        dispatch_stall;

   int n_tests = 0;
   int n_fail  = 0;

   logic [39:0] mq [3][$];
   int          wt [3];
   logic [7:0]  e_tag;
   logic [31:0] e_data;
   logic [1:0]  e_src;

   always #5 clk = ~clk;

   cdb_broadcast_scheduler #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .STALL_THRESH(THRESH)) dut (
      .clk(clk), .reset(reset), .en(en),
      .mul_tag(utag[0]), .mul_data(udata[0]), .mul_ready(mul_ready),
      .add_tag(utag[1]), .add_data(udata[1]), .add_ready(add_ready),
      .mem_tag(utag[2]), .mem_data(udata[2]), .mem_ready(mem_ready),
      .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_src(cdb_src),
      .dispatch_stall(dispatch_stall)
   );

   task automatic chk(input string nm, input logic [39:0] got, input logic [39:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int u = 0; u < 3; u++) begin
         mq[u].delete();
         wt[u] = 0;
      end
      e_tag = '0; e_data = '0; e_src = '0;
   endtask

   task automatic check_all();
      int tot;
      bit full;
      tot = 0; full = 0;
      for (int u = 0; u < 3; u++) begin
         tot += mq[u].size();
         if (mq[u].size() == DEPTH) full = 1;
      end
      chk("cdb_tag",   40'(cdb_tag),   40'(e_tag));
      chk("cdb_data",  40'(cdb_data),  40'(e_data));
      chk("cdb_src",   40'(cdb_src),   40'(e_src));
      chk("mul_ready", 40'(mul_ready), 40'(mq[0].size() < DEPTH));
      chk("add_ready", 40'(add_ready), 40'(mq[1].size() < DEPTH));
      chk("mem_ready", 40'(mem_ready), 40'(mq[2].size() < DEPTH));
      chk("stall",     40'(dispatch_stall), 40'((tot >= THRESH) || full));
   endtask

   // Advance one clock: predict the edge from the rules, then compare.
   task automatic tick();
      int g;
      bit rdy [3];
      g = -1;
      for (int u = 0; u < 3; u++) rdy[u] = mq[u].size() < DEPTH;
      if (en) begin
         for (int u = 0; u < 3; u++)
            if (g < 0 && mq[u].size() > 0 && wt[u] >= LIMIT) g = u;
         for (int u = 0; u < 3; u++)
            if (g < 0 && mq[u].size() > 0) g = u;
         for (int u = 0; u < 3; u++) begin
            if (u == g || mq[u].size() == 0) wt[u] = 0;
            else if (wt[u] < LIMIT) wt[u]++;
         end
      end
      if (g >= 0) begin
         {e_tag, e_data} = mq[g].pop_front();
         e_src = 2'(g + 1);
      end else begin
         e_tag = '0; e_data = '0; e_src = '0;
      end
      for (int u = 0; u < 3; u++)
         if (utag[u][7] && rdy[u]) mq[u].push_back({utag[u], udata[u]});
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic idle_inputs();
      for (int u = 0; u < 3; u++) begin
         utag[u] = '0; udata[u] = '0;
      end
   endtask

   initial begin
      int seen;
      reset = 1'b0; en = 1'b0;
      idle_inputs();
      model_clear();
      #12;
      check_all();
      reset = 1'b1;
      en = 1'b1;

      // Single result
      utag[0] = 8'h85; udata[0] = 32'd42;
      tick();
      idle_inputs();
      tick();
      chk("single_tag", 40'(cdb_tag), 40'h85);
      chk("single_src", 40'(cdb_src), 40'd1);
      tick();
      chk("single_gone", 40'(cdb_tag), 40'h0);

      // Simultaneous completion
      utag[0] = 8'h81; utag[1] = 8'h82; utag[2] = 8'h83;
      udata[0] = 32'h111; udata[1] = 32'h222; udata[2] = 32'h333;
      tick();
      idle_inputs();
      chk("simul_stall_on", 40'(dispatch_stall), 40'd1);
      tick();
      chk("simul_first", 40'(cdb_tag), 40'h81);
      chk("simul_stall_off", 40'(dispatch_stall), 40'd0);
      tick();
      chk("simul_second", 40'(cdb_tag), 40'h82);
      tick();
      chk("simul_third", 40'(cdb_tag), 40'h83);
      tick();

      // Backpressure with broadcasting disabled
      en = 1'b0;
      utag[1] = 8'h90; udata[1] = 32'hA;
      tick();
      utag[1] = 8'h91; udata[1] = 32'hB;
      tick();
      chk("bp_add_ready", 40'(add_ready), 40'd0);
      chk("bp_stall", 40'(dispatch_stall), 40'd1);
      utag[1] = 8'h92; udata[1] = 32'hC;
      tick();
      idle_inputs();
      en = 1'b1;
      tick();
      chk("bp_first", 40'(cdb_tag), 40'h90);
      tick();
      chk("bp_second", 40'(cdb_tag), 40'h91);
      tick();
      chk("bp_dropped", 40'(cdb_tag), 40'h0);

      // Starvation: mul kept busy while one mem result ages
      seen = -1;
      for (int i = 0; i < 10; i++) begin
         utag[0] = 8'h80 | 8'(i); udata[0] = 32'(i);
         if (i == 0) begin
            utag[2] = 8'hA0; udata[2] = 32'hDEAD;
         end else begin
            utag[2] = '0;
         end
         tick();
         if (cdb_tag == 8'hA0 && seen < 0) seen = i;
      end
      chk("starve_cycle", 40'(seen), 40'd5);
      idle_inputs();
      for (int i = 0; i < 4; i++) tick();

      // Asynchronous reset mid-operation
      en = 1'b0;
      utag[0] = 8'hC1; utag[1] = 8'hC2;
      tick();
      utag[0] = 8'hC4; utag[1] = '0; utag[2] = 8'hC3;
      tick();
      idle_inputs();
      en = 1'b1;
      tick();
      chk("rst_pre_tag", 40'(cdb_tag), 40'hC1);
      #3;
      reset = 1'b0;
      #1;
      model_clear();
      check_all();
      #3;
      reset = 1'b1;
      tick();
      tick();

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         en = ($urandom_range(0, 9) != 0);
         for (int u = 0; u < 3; u++) begin
            utag[u]  = {($urandom_range(0, 2) != 0), 7'($urandom)};
            udata[u] = $urandom;
         end
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
